// File: rtl/telemetry_uart_reporter.sv
// rtl/telemetry_uart_reporter.sv - periodic/triggered ASCII telemetry frame generator feeding a UART byte interface
module telemetry_uart_reporter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 10,
    parameter int DIGITS     = 3,
    parameter int PERIOD_CYC = 33_000_000,
    parameter int MODE       = 2,
    parameter int CHECKSUM   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     trigger,
    output logic [7:0]               tx_data,
    output logic                     tx_data_valid,
    input  logic                     tx_data_ready,
    output logic                     busy,
    output logic [7:0]               overrun_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_LABEL = 3'd3;
    localparam logic [2:0] S_DIG   = 3'd4;
    localparam logic [2:0] S_SEP   = 3'd5;
    localparam logic [2:0] S_CSUM  = 3'd6;
    localparam logic [2:0] S_EOL   = 3'd7;

    localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [2:0]               state;
    logic [2:0]               idx;
    logic [2:0]               ch_idx;
    logic [4:0]               cnt;
    logic [NUM_CH*DATA_W-1:0] snap;
    logic [DATA_W-1:0]        bin;
    logic [19:0]              bcd;
    logic [19:0]              bcd_adj;
    logic [7:0]               csum;
    logic                     pending;
    logic [PW-1:0]            pcnt;
    logic                     tick;
    logic                     req;
    logic                     accept;
    logic                     sat;
    logic [2:0]               dsel;
    logic [7:0]               byte_out;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    assign tick          = (pcnt == PW'(PERIOD_CYC - 1));
    assign req           = (tick && (MODE != 1)) || (trigger && (MODE != 0));
    assign busy          = (state != S_IDLE);
    assign tx_data_valid = (state == S_LABEL) || (state == S_DIG) || (state == S_SEP) ||
                           (state == S_CSUM)  || (state == S_EOL);
    assign accept        = tx_data_valid && tx_data_ready;
    assign tx_data       = byte_out;

    // Five BCD digits cover any 16-bit value; digits above DIGITS only flag saturation.
    always_comb begin
        bcd_adj = bcd;
        sat     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            if (i >= DIGITS && bcd[4*i +: 4] != 4'd0)
                sat = 1'b1;
        end
    end

    always_comb begin
        byte_out = 8'h00;
        dsel     = 3'(DIGITS - 1) - idx;
        case (state)
            S_LABEL: begin
                if (idx == 3'd0)      byte_out = 8'h43;
                else if (idx == 3'd1) byte_out = 8'h30 + {5'd0, ch_idx};
                else                  byte_out = 8'h3A;
            end
            S_DIG:   byte_out = sat ? 8'h39 : {4'h3, bcd[{dsel, 2'b00} +: 4]};
            S_SEP:   byte_out = 8'h2C;
            S_CSUM: begin
                if (idx == 3'd0)      byte_out = 8'h2A;
                else if (idx == 3'd1) byte_out = hex_char(csum[7:4]);
                else                  byte_out = hex_char(csum[3:0]);
            end
            S_EOL:   byte_out = (idx == 3'd0) ? 8'h0D : 8'h0A;
            default: byte_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            ch_idx      <= '0;
            cnt         <= '0;
            snap        <= '0;
            bin         <= '0;
            bcd         <= '0;
            csum        <= '0;
            pending     <= 1'b0;
            pcnt        <= '0;
            overrun_cnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);

            if (state != S_IDLE && req) begin
                if (!pending)
                    pending <= 1'b1;
                else if (overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end

            if (accept && (state == S_LABEL || state == S_DIG || state == S_SEP))
                csum <= csum ^ byte_out;

            case (state)
                S_IDLE: begin
                    if (req || pending) begin
                        state   <= S_LATCH;
                        pending <= pending && req;
                    end
                end
                S_LATCH: begin
                    snap   <= ch_data;
                    ch_idx <= '0;
                    cnt    <= '0;
                    csum   <= '0;
                    state  <= S_CONV;
                end
                S_CONV: begin
                    if (cnt == 5'd0) begin
                        bin <= snap[ch_idx*DATA_W +: DATA_W];
                        bcd <= '0;
                        cnt <= 5'd1;
                    end else begin
                        bcd <= {bcd_adj[18:0], bin[DATA_W-1]};
                        bin <= bin << 1;
                        if (cnt == 5'(DATA_W)) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= S_LABEL;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                S_LABEL: begin
                    if (accept) begin
                        if (idx == 3'd2) begin
                            idx   <= '0;
                            state <= S_DIG;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_DIG: begin
                    if (accept) begin
                        if (idx == 3'(DIGITS - 1)) begin
                            idx <= '0;
                            if (ch_idx == 3'(NUM_CH - 1))
                                state <= (CHECKSUM != 0) ? S_CSUM : S_EOL;
                            else
                                state <= S_SEP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_SEP: begin
                    if (accept) begin
                        ch_idx <= ch_idx + 3'd1;
                        state  <= S_CONV;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (idx == 3'd2) begin
                            idx   <= '0;
                            state <= S_EOL;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        if (idx == 3'd1) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_uart_reporter.sv
// tb/tb_telemetry_uart_reporter.sv - scoreboard bench for telemetry_uart_reporter
module tb_telemetry_uart_reporter;

    localparam int DATA_W = 10;

    logic        clk = 1'b0;
    logic        rst_n, trigger, tx_data_ready;
    logic [19:0] ch_data;
    logic [7:0]  tx_data, overrun_cnt;
    logic        tx_data_valid, busy;

    logic        b_rst_n, b_trigger;
    logic        b_ready = 1'b1;
    logic [9:0]  b_ch = 10'd321;
    logic [7:0]  b_tx_data, b_ovr;
    logic        b_valid, b_busy;

    int          total = 0;
    int          bad = 0;
    int          rx_count = 0;
    int          cyc = 0;
    int          b_rel = 0;
    logic [7:0]  exp_q[$];
    int          rises[$];
    logic        held = 1'b0;
    logic [7:0]  held_data = 8'h00;
    logic        b_prev = 1'b0;

    always #5 clk = ~clk;

    telemetry_uart_reporter dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .trigger(trigger),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    telemetry_uart_reporter #(
        .NUM_CH(1), .DATA_W(10), .DIGITS(3), .PERIOD_CYC(1000), .MODE(0), .CHECKSUM(0)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .ch_data(b_ch), .trigger(b_trigger),
        .tx_data(b_tx_data), .tx_data_valid(b_valid), .tx_data_ready(b_ready),
        .busy(b_busy), .overrun_cnt(b_ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    function automatic void push_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void push_frame(input int v0, input int v1);
        logic [7:0] f[$];
        logic [7:0] x;
        int v;
        for (int c = 0; c < 2; c++) begin
            v = (c == 0) ? v0 : v1;
            if (v > 999) v = 999;
            if (c > 0) f.push_back(8'h2C);
            f.push_back(8'h43);
            f.push_back(8'(48 + c));
            f.push_back(8'h3A);
            f.push_back(8'(48 + v / 100));
            f.push_back(8'(48 + (v / 10) % 10));
            f.push_back(8'(48 + v % 10));
        end
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(8'h2A);
        f.push_back(hexc(x[7:4]));
        f.push_back(hexc(x[3:0]));
        foreach (f[i]) exp_q.push_back(f[i]);
        push_crlf();
    endfunction

    // Monitor: every accepted byte is popped and compared; stalled bytes must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", tx_data_valid, 1);
                check("hold_data", tx_data, held_data);
            end
            if (tx_data_valid && tx_data_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    check("byte", tx_data, exp_q.pop_front());
                end
                rx_count++;
            end
            held      = tx_data_valid && !tx_data_ready;
            held_data = tx_data;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (b_busy && !b_prev) rises.push_back(cyc);
        b_prev = b_busy;
    end

    task automatic pulse_trig();
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    task automatic wait_rx(input int target);
        bit done = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (rx_count >= target) begin
                done = 1;
                break;
            end
        end
        check("wait_rx", done, 1);
    endtask

    initial begin
        b_rst_n = 1'b0;
        b_trigger = 1'b0;
        wait (b_rst_n === 1'b1);
        repeat (300) @(posedge clk);
        #1 b_trigger = 1'b1;
        @(posedge clk);
        #1 b_trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("b_trigger_ignored", b_busy, 0);
        end
    end

    initial begin
        int lat;
        bit found;
        int start;
        rst_n = 1'b0;
        trigger = 1'b0;
        tx_data_ready = 1'b1;
        ch_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_b_valid", b_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b_rst_n = 1'b1;
        b_rel = cyc;

        // Frame 1: hand-computed reference frame and request latency.
        ch_data = {10'd75, 10'd95};
        push_str("C0:095,C1:075*23");
        push_crlf();
        trigger = 1'b1;
        lat = 0;
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) trigger = 1'b0;
            if (tx_data_valid) begin
                lat = n - 1;
                found = 1;
                break;
            end
        end
        check("first_valid_seen", found, 1);
        check("latency_bound", (lat <= DATA_W + 3), 1);
        wait_done("frame1_done");
        check("frame1_busy_low", busy, 0);

        // Saturation of an out-of-range value.
        ch_data = {10'd0, 10'd1023};
        push_str("C0:999,C1:000*24");
        push_crlf();
        pulse_trig();
        wait_done("sat_done");

        // Stall mid-frame and change inputs after the snapshot.
        ch_data = {10'd7, 10'd512};
        push_frame(512, 7);
        start = rx_count;
        pulse_trig();
        @(posedge clk);
        #1 ch_data = {10'd999, 10'd1};
        wait_rx(start + 5);
        tx_data_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1 tx_data_ready = 1'b1;
        wait_done("stall_done");

        // Three extra requests during a frame: one pending frame, two overruns.
        ch_data = {10'd300, 10'd42};
        push_frame(42, 300);
        push_frame(42, 300);
        pulse_trig();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 pulse_trig();
        end
        wait_done("overrun_done");
        check("overrun_cnt", overrun_cnt, 2);

        // Reset while byte 5 is presented, then a clean restart.
        ch_data = {10'd8, 10'd64};
        push_frame(64, 8);
        start = rx_count;
        pulse_trig();
        wait_rx(start + 4);
        check("byte5_presented", {tx_data_valid, tx_data}, {1'b1, 8'h36});
        rst_n = 1'b0;
        #1;
        check("midrst_valid", tx_data_valid, 0);
        check("midrst_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_frame(64, 8);
        pulse_trig();
        wait_done("restart_done");

        // Periodic-only instance: frames every 1000 cycles from release.
        while (cyc < b_rel + 3100) @(posedge clk);
        #1;
        check("b_frame_count", rises.size(), 3);
        for (int i = 0; i < rises.size(); i++)
            check("b_period", rises[i] - ((i == 0) ? b_rel : rises[i-1]), 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
